regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/rd/write_data) between two writeback requesters: the ALU path and the multi-cycle load unit.
- Keeps a 32-entry busy scoreboard of outstanding load destinations and produces the decode-stage stall for RAW and WAW hazards.
- Sits between the execute/memory stages and the 32x32 register file; x0 is never written or tracked.

Parameters:
- XLEN, 32, data width of write_data.
- STARVE_LIMIT, 4, consecutive cycles a pending load may be deferred before it gets priority.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  5  ALU destination.
- alu_data  input  XLEN  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- ld_valid  input  1  load writeback request.
- ld_rd  input  5  load destination.
- ld_data  input  XLEN  load data.
- ld_ready  output  1  load request accepted this cycle.
- issue_load  input  1  decode issues a load this cycle.
- issue_rd  input  5  destination of the issued load.
- rs1  input  5  decode source 1.
- rs2  input  5  decode source 2.
- dst  input  5  decode destination, for the WAW check.
- stall  output  1  decode must hold.
- RegWrite  output  1  register-file write enable (registered).
- rd  output  5  register-file write address (registered).
- write_data  output  XLEN  register-file write data (registered).

Behaviour:
- Reset (synchronous): RegWrite=0, rd=0, write_data=0, busy=0, defer_cnt=0, state=ALU_PRI.
- All three outputs stay at these values while reset is high, including when reset lands mid-request.
- Arbitration is combinational. At most one of alu_ready/ld_ready is high per cycle.
  - ALU_PRI: alu_valid wins. Otherwise ld_valid wins.
  - LD_PRI: ld_valid wins. Otherwise alu_valid wins.
- Requests with rd==0 are accepted (ready=1) and discarded: RegWrite stays 0 and no scoreboard change.
- Requesters hold valid/rd/data stable until their ready is sampled high.
- Latency: the granted request appears on RegWrite/rd/write_data at the next rising edge and stays for exactly one cycle. With no grant, RegWrite=0 and rd/write_data hold their previous values.
- Back-to-back grants every cycle are allowed, giving full throughput.
- Starvation counter (defer_cnt, saturating at STARVE_LIMIT):
  - Increments each cycle ld_valid=1 and ld_ready=0.
  - Clears to 0 on a load grant or when ld_valid=0.
- FSM:
  - ALU_PRI -> LD_PRI when defer_cnt reaches STARVE_LIMIT-1 and the load is deferred again this cycle.
  - LD_PRI -> ALU_PRI after any load grant, or when ld_valid=0.
- Scoreboard busy[31:1]; busy[0] is constant 0.
  - Set: issue_load=1 and issue_rd!=0 sets busy[issue_rd].
  - Clear: a load grant clears busy[ld_rd].
  - Same rd set and cleared in one cycle: set wins, because the new load is outstanding.
- Stall is combinational. stall=1 if any of:
  - busy[rs1] or busy[rs2];
  - issue_load and busy[dst];
  - RegWrite=1 and rd!=0 and rd equals rs1 or rs2. The write lands only at the next edge, so there is no bypass.
- A source index of 0 never causes a stall.
- issue_load is honoured regardless of stall. Decode gates issue_load with stall itself.
- ALU writes to a busy rd are not blocked; decode prevents them via the WAW stall.

Decomposition:
- Shared package rv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, typedef wb_req_t {valid, rd[4:0], data[XLEN-1:0]}, enum arb_state_t {ALU_PRI, LD_PRI}.
- One natural sub-module: regfile_scoreboard, holding the busy vector with set/clear ports and the combinational hazard lookup.
- Arbiter FSM, starvation counter and output register stay in the top module.

Test Plan:
- Reset checks: assert reset for 2 cycles with alu_valid=1, alu_rd=5 -> RegWrite=0, rd=0, write_data=0, stall=0 throughout. First post-reset cycle grants ALU; next cycle RegWrite=1, rd=5.
- Single ALU write: alu_valid=1, rd=3, data=0xDEADBEEF -> alu_ready=1 same cycle. Next cycle RegWrite=1, rd=3, write_data=0xDEADBEEF, and stall=1 while rs1=3.
- Starvation: ld_valid=1 (rd=7, data=0x11) and alu_valid=1 every cycle -> ALU granted for 4 cycles, load granted on cycle 5 (alu_ready=0), ALU resumes on cycle 6.
- Load hazard: issue_load with issue_rd=9, then rs2=9 -> stall=1 until the load (rd=9, data=0x55) is granted. stall stays 1 the following cycle (output-stage match), then 0.
- Same-cycle set/clear: load grant for rd=9 and issue_load with issue_rd=9 in the same cycle -> busy[9] remains 1 and stall stays 1 for rs1=9.
- x0 handling: alu_valid with rd=0 -> alu_ready=1, RegWrite stays 0. issue_load with issue_rd=0 followed by rs1=0 -> stall=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file definitions: widths, register count, writeback request
// bundle and arbiter priority states.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LD_PRI  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard of outstanding load destinations with a combinational
// RAW/WAW lookup. Entry 0 is hard-wired clear.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] dst,
    input  logic                  check_dst,
    output logic                  hazard
);

    logic [NUM_REGS-1:1] busy_reg;
    logic [NUM_REGS-1:1] busy_next;
    logic [NUM_REGS-1:0] busy_vec;

    // A set in the same cycle as a clear wins: the newly issued load is outstanding.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_next[gi] = (set_en && (set_rd == REG_ADDR_W'(gi)))
                                || (busy_reg[gi] && !(clr_en && (clr_rd == REG_ADDR_W'(gi))));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = {busy_reg, 1'b0};
    assign hazard   = busy_vec[rs1] || busy_vec[rs2] || (check_dst && busy_vec[dst]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the load
// unit, with starvation-bounded priority and decode hazard stall generation.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN         = rv_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  issue_load,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] dst,
    output logic                  stall,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data
);

    localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       state_reg;
    logic [CNT_W-1:0] defer_cnt_reg;
    logic             alu_win;
    logic             ld_win;
    logic             ld_deferred;
    logic             sb_hazard;

    always_comb begin
        alu_win = alu_valid && ((state_reg == ALU_PRI) || !ld_valid);
        ld_win  = ld_valid && !alu_win;
    end

    assign alu_ready   = alu_win;
    assign ld_ready    = ld_win;
    assign ld_deferred = ld_valid && !ld_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ALU_PRI;
            defer_cnt_reg <= '0;
            RegWrite      <= 1'b0;
            rd            <= '0;
            write_data    <= '0;
        end else begin
            if (ld_deferred) begin
                if (defer_cnt_reg != CNT_SAT) begin
                    defer_cnt_reg <= defer_cnt_reg + 1'b1;
                end
            end else begin
                defer_cnt_reg <= '0;
            end

            case (state_reg)
                ALU_PRI: if (ld_deferred && (defer_cnt_reg >= CNT_TRIP)) state_reg <= LD_PRI;
                LD_PRI:  if (!ld_deferred) state_reg <= ALU_PRI;
                default: state_reg <= ALU_PRI;
            endcase

            // Grants to x0 are accepted but never reach the register file.
            if (alu_win && (alu_rd != '0)) begin
                RegWrite   <= 1'b1;
                rd         <= alu_rd;
                write_data <= alu_data;
            end else if (ld_win && (ld_rd != '0)) begin
                RegWrite   <= 1'b1;
                rd         <= ld_rd;
                write_data <= ld_data;
            end else begin
                RegWrite   <= 1'b0;
            end
        end
    end

    regfile_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (issue_load),
        .set_rd    (issue_rd),
        .clr_en    (ld_win),
        .clr_rd    (ld_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .dst       (dst),
        .check_dst (issue_load),
        .hazard    (sb_hazard)
    );

    // The pending write lands only at the next edge, so it must also stall readers.
    assign stall = sb_hazard
                || (RegWrite && (rd != '0) && ((rd == rs1) || (rd == rs2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a
// behavioural model of grants, priority aging, busy registers and stall.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        issue_load;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dst;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .issue_load (issue_load),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .dst        (dst),
        .stall      (stall),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .write_data (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_load_first;
    int          m_deferred;
    bit          m_we;
    bit [4:0]    m_rd;
    bit [31:0]   m_wd;

    bit          e_alu;
    bit          e_ld;
    logic        s_alu_ready;
    logic        s_ld_ready;
    logic        s_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_load_first = 1'b0;
        m_deferred   = 0;
        m_we         = 1'b0;
        m_rd         = '0;
        m_wd         = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic tick();
        bit ea, el, es;
        #1;
        el = ld_valid && (m_load_first || !alu_valid);
        ea = alu_valid && !el;
        es = m_busy[rs1] || m_busy[rs2] || (issue_load && m_busy[dst])
          || (m_we && m_rd != 0 && (m_rd == rs1 || m_rd == rs2));
        s_alu_ready = alu_ready;
        s_ld_ready  = ld_ready;
        s_stall     = stall;
        check("alu_ready", alu_ready, ea);
        check("ld_ready", ld_ready, el);
        check("stall", stall, es);
        e_alu = ea;
        e_ld  = el;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (ea && alu_rd != 0) begin
                m_we = 1'b1; m_rd = alu_rd; m_wd = alu_data;
            end else if (el && ld_rd != 0) begin
                m_we = 1'b1; m_rd = ld_rd; m_wd = ld_data;
            end
            if (el) m_busy[ld_rd] = 1'b0;
            if (issue_load) m_busy[issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (ld_valid && !el) begin
                m_deferred = (m_deferred + 1 > LIMIT) ? LIMIT : m_deferred + 1;
                if (m_deferred >= LIMIT) m_load_first = 1'b1;
            end else begin
                m_deferred   = 0;
                m_load_first = 1'b0;
            end
        end
        #1;
        check("RegWrite", RegWrite, m_we);
        check("rd", rd, m_rd);
        check("write_data", write_data, m_wd);
    endtask

    initial begin
        bit alu_pend;
        bit ld_pend;

        // Reset with an ALU request held high
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_0005;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        issue_load = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0; dst = '0;
        model_reset();
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_regwrite", RegWrite, 0);
            check("reset_rd", rd, 0);
            check("reset_wdata", write_data, 0);
            check("reset_stall", s_stall, 0);
        end
        reset = 1'b0;
        tick();
        check("post_reset_grant", s_alu_ready, 1);
        check("post_reset_regwrite", RegWrite, 1);
        check("post_reset_rd", rd, 5);

        // Single ALU write followed by a read of the same register
        alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
        tick();
        check("alu3_ready", s_alu_ready, 1);
        check("alu3_rd", rd, 3);
        check("alu3_wdata", write_data, 32'hDEAD_BEEF);
        alu_valid = 1'b0; rs1 = 5'd3;
        tick();
        check("alu3_stall", s_stall, 1);
        rs1 = '0;

        // Starvation: load aged to priority on the fifth cycle
        ld_rd = 5'd7; ld_data = 32'h11;
        for (int c = 1; c <= 6; c++) begin
            ld_valid  = (c <= 5);
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100 + c;
            tick();
            check("starve_alu_ready", s_alu_ready, (c != 5));
            check("starve_ld_ready", s_ld_ready, (c == 5));
            if (c == 5) begin
                check("starve_ld_rd", rd, 7);
                check("starve_ld_wdata", write_data, 32'h11);
            end
        end
        alu_valid = 1'b0;

        // Load hazard on rs2
        issue_load = 1'b1; issue_rd = 5'd9; dst = 5'd9;
        tick();
        issue_load = 1'b0; rs2 = 5'd9;
        tick();
        check("ldhaz_busy", s_stall, 1);
        tick();
        check("ldhaz_busy2", s_stall, 1);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h55;
        tick();
        check("ldhaz_grant", s_ld_ready, 1);
        check("ldhaz_grant_stall", s_stall, 1);
        ld_valid = 1'b0;
        tick();
        check("ldhaz_wb_stall", s_stall, 1);
        tick();
        check("ldhaz_clear", s_stall, 0);
        rs2 = '0;

        // Same-cycle set and clear of register 9
        issue_load = 1'b1; issue_rd = 5'd9;
        tick();
        ld_valid = 1'b1; rs1 = 5'd9;
        tick();
        check("setclr_grant", s_ld_ready, 1);
        ld_valid = 1'b0; issue_load = 1'b0;
        tick();
        tick();
        check("setclr_still_busy", s_stall, 1);
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0; rs1 = '0;
        tick();

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        check("x0_ready", s_alu_ready, 1);
        check("x0_regwrite", RegWrite, 0);
        alu_valid = 1'b0;
        issue_load = 1'b1; issue_rd = 5'd0; dst = 5'd0;
        tick();
        issue_load = 1'b0;
        tick();
        check("x0_stall", s_stall, 0);

        // Randomized traffic with requesters holding until accepted
        alu_pend = 1'b0;
        ld_pend  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(99) == 0);
            if (!alu_pend) begin
                alu_valid = ($urandom_range(99) < 75);
                alu_rd    = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!ld_pend) begin
                ld_valid = ($urandom_range(99) < 45);
                ld_rd    = 5'($urandom);
                ld_data  = $urandom;
            end
            issue_load = ($urandom_range(99) < 25);
            issue_rd   = 5'($urandom);
            rs1        = 5'($urandom);
            rs2        = 5'($urandom);
            dst        = 5'($urandom);
            tick();
            alu_pend = alu_valid && !e_alu;
            ld_pend  = ld_valid && !e_ld;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
